rename_freelist: RTL and testbench

//  Physical-register free list feeding the 4-wide rename stage. Circular FIFO of

---
 rtl/rename_freelist.sv | 130 +++++++++++++
 tb/tb_rename_freelist.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/rename_freelist.sv
// Physical-register free list for the 4-wide rename stage: a circular FIFO of free
// PRF tags, popped by rename at the head and refilled by ROB commit at the tail.
module rename_freelist #(
    parameter int PRF_WIDTH = 6,
    parameter int NUM_PRF   = 64,
    parameter int NUM_ARF   = 32
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  alloc_valid_i,
    input  logic [3:0]                            alloc_mask_i,
    output logic                                  alloc_ready_o,
    output logic [PRF_WIDTH-1:0]                  alloc_prd0_o,
    output logic [PRF_WIDTH-1:0]                  alloc_prd1_o,
    output logic [PRF_WIDTH-1:0]                  alloc_prd2_o,
    output logic [PRF_WIDTH-1:0]                  alloc_prd3_o,
    input  logic [3:0]                            rel_valid_i,
    input  logic [PRF_WIDTH-1:0]                  rel_prd0_i,
    input  logic [PRF_WIDTH-1:0]                  rel_prd1_i,
    input  logic [PRF_WIDTH-1:0]                  rel_prd2_i,
    input  logic [PRF_WIDTH-1:0]                  rel_prd3_i,
    output logic [$clog2(NUM_PRF-NUM_ARF):0]      free_count_o,
    output logic                                  overflow_err_o
);

    localparam int DEPTH = NUM_PRF - NUM_ARF;
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    function automatic logic [2:0] popcnt4(input logic [3:0] v);
        return {2'b00, v[0]} + {2'b00, v[1]} + {2'b00, v[2]} + {2'b00, v[3]};
    endfunction

    logic [PRF_WIDTH-1:0] entry_q [DEPTH];
    logic [PTR_W-1:0]     head_q, head_d;
    logic [PTR_W-1:0]     tail_q, tail_d;
    logic [CNT_W-1:0]     count_q, count_d;
    logic                 err_q, err_d;

    logic [2:0]           alloc_off_s [4];
    logic [2:0]           rel_off_s [4];
    logic [PRF_WIDTH-1:0] alloc_prd_s [4];
    logic [PRF_WIDTH-1:0] rel_prd_s [4];
    logic [PTR_W-1:0]     wr_idx_s [4];
    logic [3:0]           wr_en_s;
    logic [2:0]           nalloc_s, nrel_s, take_s;
    logic [CNT_W:0]       sum_s;
    logic                 fire_s, ovf_s;

    assign rel_prd_s[0] = rel_prd0_i;
    assign rel_prd_s[1] = rel_prd1_i;
    assign rel_prd_s[2] = rel_prd2_i;
    assign rel_prd_s[3] = rel_prd3_i;

    assign alloc_prd0_o   = alloc_prd_s[0];
    assign alloc_prd1_o   = alloc_prd_s[1];
    assign alloc_prd2_o   = alloc_prd_s[2];
    assign alloc_prd3_o   = alloc_prd_s[3];
    assign free_count_o   = count_q;
    assign overflow_err_o = err_q;

    // Slot offsets compact masked slots onto consecutive FIFO entries.
    always_comb begin
        alloc_off_s[0] = 3'd0;
        alloc_off_s[1] = popcnt4({3'b000, alloc_mask_i[0]});
        alloc_off_s[2] = popcnt4({2'b00, alloc_mask_i[1:0]});
        alloc_off_s[3] = popcnt4({1'b0, alloc_mask_i[2:0]});
        rel_off_s[0]   = 3'd0;
        rel_off_s[1]   = popcnt4({3'b000, rel_valid_i[0]});
        rel_off_s[2]   = popcnt4({2'b00, rel_valid_i[1:0]});
        rel_off_s[3]   = popcnt4({1'b0, rel_valid_i[2:0]});
        for (int i = 0; i < 4; i++) begin
            alloc_prd_s[i] = entry_q[head_q + PTR_W'(alloc_off_s[i])];
            wr_idx_s[i]    = tail_q + PTR_W'(rel_off_s[i]);
        end
    end

    // Readiness only credits tags already held; same-cycle releases are not bypassed.
    always_comb begin
        nalloc_s      = popcnt4(alloc_mask_i);
        nrel_s        = popcnt4(rel_valid_i);
        alloc_ready_o = (count_q >= CNT_W'(nalloc_s));
        fire_s        = alloc_valid_i & alloc_ready_o;
        take_s        = fire_s ? nalloc_s : 3'd0;
        sum_s         = {1'b0, count_q} - (CNT_W+1)'(take_s) + (CNT_W+1)'(nrel_s);
        ovf_s         = (sum_s > (CNT_W+1)'(DEPTH));
        head_d        = head_q + PTR_W'(take_s);
        err_d         = err_q | ovf_s;
        if (ovf_s) begin
            count_d = count_q - CNT_W'(take_s);
            tail_d  = tail_q;
            wr_en_s = 4'b0000;
        end else begin
            count_d = sum_s[CNT_W-1:0];
            tail_d  = tail_q + PTR_W'(nrel_s);
            wr_en_s = rel_valid_i;
        end
    end

    // Pointer, count and sticky error state.
    always_ff @(posedge clk) begin
        if (rst) begin
            head_q  <= {PTR_W{1'b0}};
            tail_q  <= {PTR_W{1'b0}};
            count_q <= CNT_W'(DEPTH);
            err_q   <= 1'b0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            err_q   <= err_d;
        end
    end

    // FIFO storage; reset hands out the non-architectural tags in order.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                entry_q[i] <= PRF_WIDTH'(NUM_ARF + i);
            end
        end else begin
            for (int j = 0; j < 4; j++) begin
                if (wr_en_s[j]) begin
                    entry_q[wr_idx_s[j]] <= rel_prd_s[j];
                end
            end
        end
    end

endmodule

// File: tb/tb_rename_freelist.sv
// Directed self-checking bench for rename_freelist with hand-computed expectations
// and a small FIFO model for the wrap-around run.
module tb_rename_freelist;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       alloc_valid = 1'b0;
    logic [3:0] alloc_mask = 4'b0000;
    logic       alloc_ready;
    logic [5:0] prd0, prd1, prd2, prd3;
    logic [3:0] rel_valid = 4'b0000;
    logic [5:0] rel0 = 6'd0, rel1 = 6'd0, rel2 = 6'd0, rel3 = 6'd0;
    logic [5:0] free_count;
    logic       overflow_err;

    int n_checks = 0;
    int n_fail   = 0;

    rename_freelist dut (
        .clk           (clk),
        .rst           (rst),
        .alloc_valid_i (alloc_valid),
        .alloc_mask_i  (alloc_mask),
        .alloc_ready_o (alloc_ready),
        .alloc_prd0_o  (prd0),
        .alloc_prd1_o  (prd1),
        .alloc_prd2_o  (prd2),
        .alloc_prd3_o  (prd3),
        .rel_valid_i   (rel_valid),
        .rel_prd0_i    (rel0),
        .rel_prd1_i    (rel1),
        .rel_prd2_i    (rel2),
        .rel_prd3_i    (rel3),
        .free_count_o  (free_count),
        .overflow_err_o(overflow_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        alloc_valid = 1'b0;
        alloc_mask  = 4'b0000;
        rel_valid   = 4'b0000;
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    int q[$];
    int ea, eb;

    initial begin
        // 1: reset state
        do_reset();
        alloc_mask = 4'b1111;
        #1;
        chk("rst_count", 32'(free_count), 32);
        chk("rst_prd0", 32'(prd0), 32);
        chk("rst_prd1", 32'(prd1), 33);
        chk("rst_prd2", 32'(prd2), 34);
        chk("rst_prd3", 32'(prd3), 35);
        chk("rst_ready", 32'(alloc_ready), 1);
        chk("rst_err", 32'(overflow_err), 0);

        // 2: compacted alloc with a hole at slot 2
        alloc_valid = 1'b1;
        alloc_mask  = 4'b1011;
        #1;
        chk("cmp_prd0", 32'(prd0), 32);
        chk("cmp_prd1", 32'(prd1), 33);
        chk("cmp_prd3", 32'(prd3), 34);
        tick();
        alloc_valid = 1'b0;
        alloc_mask  = 4'b1111;
        #1;
        chk("cmp_count", 32'(free_count), 29);
        chk("cmp_next_prd0", 32'(prd0), 35);

        // 3: drain to empty
        do_reset();
        alloc_valid = 1'b1;
        alloc_mask  = 4'b1111;
        for (int i = 0; i < 8; i++) tick();
        alloc_mask = 4'b0001;
        #1;
        chk("empty_count", 32'(free_count), 0);
        chk("empty_ready_0001", 32'(alloc_ready), 0);
        tick();
        chk("empty_frozen_count", 32'(free_count), 0);
        alloc_mask = 4'b0000;
        #1;
        chk("empty_ready_0000", 32'(alloc_ready), 1);
        tick();
        chk("empty_mask0_count", 32'(free_count), 0);

        // 4: release into empty list with a gap in slot 1
        idle();
        rel_valid = 4'b1101;
        rel0 = 6'd5; rel1 = 6'd7; rel2 = 6'd12; rel3 = 6'd40;
        tick();
        idle();
        alloc_mask = 4'b0111;
        #1;
        chk("rel_count", 32'(free_count), 3);
        chk("rel_prd0", 32'(prd0), 5);
        chk("rel_prd1", 32'(prd1), 12);
        chk("rel_prd2", 32'(prd2), 40);

        // 5: alloc + release in the same cycle, no bypass
        do_reset();
        alloc_valid = 1'b1;
        alloc_mask  = 4'b1111;
        for (int i = 0; i < 7; i++) tick();
        rel_valid = 4'b1111;
        rel0 = 6'd1; rel1 = 6'd2; rel2 = 6'd3; rel3 = 6'd4;
        #1;
        chk("byp_count_before", 32'(free_count), 4);
        chk("byp_ready", 32'(alloc_ready), 1);
        chk("byp_prd0", 32'(prd0), 60);
        chk("byp_prd1", 32'(prd1), 61);
        chk("byp_prd2", 32'(prd2), 62);
        chk("byp_prd3", 32'(prd3), 63);
        tick();
        idle();
        alloc_mask = 4'b1111;
        #1;
        chk("byp_count_after", 32'(free_count), 4);
        chk("byp_next_prd0", 32'(prd0), 1);
        chk("byp_next_prd1", 32'(prd1), 2);
        chk("byp_next_prd2", 32'(prd2), 3);
        chk("byp_next_prd3", 32'(prd3), 4);

        // 6: overflow on a full list drops the release and sticks
        do_reset();
        rel_valid = 4'b0001;
        rel0 = 6'd9;
        tick();
        idle();
        alloc_mask = 4'b1111;
        #1;
        chk("ovf_err", 32'(overflow_err), 1);
        chk("ovf_count", 32'(free_count), 32);
        chk("ovf_nowrite_prd0", 32'(prd0), 32);
        // Overflowing release alongside an alloc: alloc still proceeds
        alloc_valid = 1'b1;
        alloc_mask  = 4'b0001;
        rel_valid   = 4'b0011;
        rel0 = 6'd9; rel1 = 6'd10;
        tick();
        idle();
        alloc_mask = 4'b1111;
        #1;
        chk("ovf_alloc_count", 32'(free_count), 31);
        chk("ovf_alloc_prd0", 32'(prd0), 33);
        for (int i = 0; i < 11; i++) tick();
        chk("ovf_sticky", 32'(overflow_err), 1);
        do_reset();
        chk("ovf_rst_clear", 32'(overflow_err), 0);

        // Wrap: alloc two, release them swapped through sparse slots, 40 cycles
        q.delete();
        for (int i = 32; i < 64; i++) q.push_back(i);
        for (int c = 0; c < 40; c++) begin
            ea = q[0];
            eb = q[1];
            alloc_valid = 1'b1;
            alloc_mask  = 4'b0101;
            rel_valid   = 4'b1010;
            rel0 = 6'd0; rel1 = 6'(eb); rel2 = 6'd0; rel3 = 6'(ea);
            #1;
            chk("wrap_prd0", 32'(prd0), 32'(ea));
            chk("wrap_prd2", 32'(prd2), 32'(eb));
            tick();
            void'(q.pop_front());
            void'(q.pop_front());
            q.push_back(eb);
            q.push_back(ea);
        end
        idle();
        #1;
        chk("wrap_count", 32'(free_count), 32'(q.size()));
        chk("wrap_err", 32'(overflow_err), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
